result_uart_tx: RTL and testbench
=================================

# result_uart_tx

Serial reporter at the output end of the processor's result interface. It captures each `{flags, result}` snapshot that the processor core publishes every sample period, buffers it in a small FIFO, and transmits it as a fixed-length 8N1 UART frame on a single pin. Board-level debug tools and the lab bench use this frame to read back results without a logic analyser.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit; 434 gives 115200 baud at 50 MHz. Legal range is 2..65535.
- `FIFO_DEPTH`, default 2: number of record entries. Must be a power of 2 and at least 2.

Ports:
- `CLOCK_50`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `result_valid`, input, 1: one-cycle pulse; the snapshot is present on the data inputs.
- `result_in`, input, 32: result word.
- `flags_in`, input, 4: NZCV flags, with N in bit 3.
- `uart_txd`, output, 1: serial line. Idle level is 1.
- `busy`, output, 1: high when the FSM is not in IDLE or the FIFO is not empty.
- `overflow`, output, 1: sticky flag; a snapshot was dropped because the FIFO was full.

## Operation
- Record format is 36 bits: `{flags_in, result_in}`, captured on every edge where `result_valid`=1.
- Frame byte sequence:
  - B0 = `{4'hA, flags}`
  - B1..B4 = result[31:24], [23:16], [15:8], [7:0]
- Byte encoding is 8N1:
  - 1 start bit (0)
  - 8 data bits, LSB first
  - 1 stop bit (1)
- Bytes inside a frame are sent back-to-back with no idle gap.
- FSM states and transitions:
  - IDLE: when the FIFO is not empty, pop the head record, set byte_idx=0, load B0 into the shift register, and go to START.
  - START: drive txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: drive txd=1 for CLKS_PER_BIT cycles. If byte_idx is the last byte, go to IDLE. Otherwise increment byte_idx, load the next byte, and go to START.
- FIFO rules:
  - Push when `result_valid`=1 and the FIFO is not full.
  - Pop only from IDLE.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - Push while full with no pop in that cycle: the snapshot is dropped, `overflow` is set to 1, and the FIFO contents are unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. Full and empty are decided from the MSB comparison of the two pointers.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and clears on every state entry.
  - bit_idx is 3 bits; byte_idx is 3 bits.
- `uart_txd` is a registered output and never glitches.

## Timing
- Reset values:
  - `uart_txd`=1, `busy`=0, `overflow`=0
  - FIFO empty, FSM in IDLE, all counters 0
- Reset mid-frame: on the reset edge the line returns to 1, the frame is abandoned, and buffered records are discarded. Reset has priority over `result_valid` on the same edge.
- Latency: with `result_valid` sampled at edge k and the FSM idle with an empty FIFO:
  - the FIFO holds the record after edge k
  - `uart_txd` falls after edge k+1
  - `busy` rises after edge k
- Frame length is 5×10×CLKS_PER_BIT cycles (6×10× when the checksum byte is enabled).
- Between consecutive buffered frames there is one IDLE cycle after the final stop bit, then the next start bit.
- `busy` falls on the edge where STOP→IDLE is taken with an empty FIFO.

## Configuration
- `RESULT_TX_CHECKSUM_EN` defined:
  - Adds B5 = B0^B1^B2^B3^B4 after B4.
  - The last byte_idx is 5.
- Macro undefined:
  - 5-byte frame; the last byte_idx is 4.
  - No XOR logic is compiled.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=2.
1. Basic frame: pulse with result=0x12345678, flags=4'b1001 → decoded bytes A9 12 34 56 78. The start bit is 4 cycles low beginning after edge k+1. Total frame is 200 cycles, and `busy` is high throughout.
2. Buffering and overflow: 4 pulses 10 cycles apart with result=1,2,3,4 → frames for results 1, 2, 3 are sent, each separated by one idle cycle. The 4th snapshot is dropped and `overflow`=1 and remains 1.
3. Full FIFO with simultaneous push and pop: a new pulse on the exact edge IDLE pops from a full FIFO → the record is accepted and `overflow` stays 0.
4. Reset mid-frame: assert `reset` during DATA of B2 → after that edge `uart_txd`=1, `busy`=0, `overflow`=0, and no further start bit appears.
5. Checksum (`RESULT_TX_CHECKSUM_EN` defined): the same stimulus as scenario 1 → bytes A9 12 34 56 78 A1, frame length 240 cycles.

Source files
------------

// File: rtl/result_uart_tx.sv
// FIFO-buffered 8N1 serial reporter for {flags, result} snapshots.
// Define RESULT_TX_CHECKSUM_EN to append an XOR checksum byte (B5) to every frame.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        result_valid,
    input  logic [31:0] result_in,
    input  logic [3:0]  flags_in,
    output logic        uart_txd,
    output logic        busy,
    output logic        overflow
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int          NUM_BYTES = 6;
`else
    localparam int          NUM_BYTES = 5;
`endif
    localparam logic [2:0]  LAST_BYTE = 3'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [35:0] rec_q, rec_d;
    logic        txd_q, txd_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic [35:0] mem_q [0:FIFO_DEPTH-1];

    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        baud_done;
    logic [35:0] head;
    logic [2:0]  next_idx;
    logic [7:0]  frame_byte [0:7];

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign push       = result_valid && (!fifo_full || pop);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign baud_done  = (baud_q == BAUD_LAST);
    assign next_idx   = byte_idx_q + 3'd1;

    assign frame_byte[0] = {4'hA, rec_q[35:32]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_result_bytes
            assign frame_byte[gi+1] = rec_q[31-8*gi -: 8];
        end
`ifdef RESULT_TX_CHECKSUM_EN
        assign frame_byte[5] = frame_byte[0] ^ frame_byte[1] ^ frame_byte[2] ^
                               frame_byte[3] ^ frame_byte[4];
`endif
        for (gi = NUM_BYTES; gi < 8; gi++) begin : g_unused_bytes
            assign frame_byte[gi] = 8'h00;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        rec_d      = rec_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (result_valid && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    rec_d      = head;
                    shift_d    = {4'hA, head[35:32]};
                    byte_idx_d = 3'd0;
                    baud_d     = 16'd0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d    = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = 16'd0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = 16'd0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = next_idx;
                        shift_d    = frame_byte[next_idx];
                        state_d    = ST_START;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The line level is derived from the next state so the pin is a plain flop.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= 16'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            shift_q    <= 8'd0;
            rec_q      <= 36'd0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            rec_q      <= rec_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {flags_in, result_in};
        end
    end

    assign uart_txd = txd_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx: a time-based transmitter model predicts
// accepted records and frame start cycles; a line monitor decodes and compares frames.
module tb_result_uart_tx;

    localparam int C = 4;
    localparam int D = 2;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int FRAME = NB * 10 * C;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        result_valid = 1'b0;
    logic [31:0] result_in = 32'd0;
    logic [3:0]  flags_in = 4'd0;
    logic        uart_txd;
    logic        busy;
    logic        overflow;

    result_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(D)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .result_valid(result_valid),
        .result_in(result_in),
        .flags_in(flags_in),
        .uart_txd(uart_txd),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  rem = 0;
    bit  ovf_exp = 1'b0;
    bit  chk_en = 1'b0;

    logic [35:0] mq[$];
    logic [35:0] sb_rec[$];
    int          sb_cyc[$];

    function automatic logic [7:0] exp_byte(input logic [35:0] rec, input int i);
        logic [7:0] b [0:5];
        b[0] = {4'hA, rec[35:32]};
        b[1] = rec[31:24];
        b[2] = rec[23:16];
        b[3] = rec[15:8];
        b[4] = rec[7:0];
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        return b[i];
    endfunction

    // Reference model: a transmitter is free once a whole frame has elapsed;
    // a record enters the buffer if there is room after any pop on that edge.
    initial begin
        bit popped;
        forever begin
            @(posedge CLOCK_50);
            cyc++;
            if (reset) begin
                mq.delete();
                sb_rec.delete();
                sb_cyc.delete();
                rem = 0;
                ovf_exp = 1'b0;
            end else begin
                popped = 1'b0;
                if (rem == 0 && mq.size() > 0) begin
                    sb_rec.push_back(mq.pop_front());
                    sb_cyc.push_back(cyc);
                    popped = 1'b1;
                    rem = FRAME;
                end else if (rem > 0) begin
                    rem--;
                end
                if (result_valid) begin
                    if (mq.size() < D) mq.push_back({flags_in, result_in});
                    else ovf_exp = 1'b1;
                end
            end
        end
    end

    // Per-cycle status checks.
    initial begin
        bit exp_busy;
        forever begin
            @(negedge CLOCK_50);
            if (chk_en) begin
                exp_busy = (rem > 0) || (mq.size() > 0);
                checks++;
                if (busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, exp_busy);
                end
                checks++;
                if (overflow !== ovf_exp) begin
                    errors++;
                    $display("FAIL overflow cyc=%0d got %b required %b", cyc, overflow, ovf_exp);
                end
                if (rem == 0) begin
                    checks++;
                    if (uart_txd !== 1'b1) begin
                        errors++;
                        $display("FAIL idle_line cyc=%0d got %b required 1", cyc, uart_txd);
                    end
                end
            end
        end
    end

    // Line monitor: decodes each frame and compares it with the scoreboard head.
    initial begin
        logic        samp [0:FRAME-1];
        logic [35:0] rec;
        logic [7:0]  got;
        bit          abort;
        bit          fr_ok;
        int          s;
        int          base;
        forever begin
            @(negedge CLOCK_50);
            if (chk_en && !reset && uart_txd === 1'b0) begin
                checks++;
                rec = '0;
                if (sb_rec.size() == 0) begin
                    errors++;
                    $display("FAIL frame_start cyc=%0d got start bit required none", cyc);
                end else begin
                    rec = sb_rec.pop_front();
                    s = sb_cyc.pop_front();
                    if (s != cyc) begin
                        errors++;
                        $display("FAIL frame_start cyc got %0d required %0d", cyc, s);
                    end
                end
                samp[0] = 1'b0;
                abort = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge CLOCK_50);
                    if (reset) begin
                        abort = 1'b1;
                        break;
                    end
                    samp[i] = uart_txd;
                end
                if (!abort) begin
                    for (int b = 0; b < NB; b++) begin
                        got = '0;
                        fr_ok = 1'b1;
                        for (int j = 0; j < 10; j++) begin
                            base = (b * 10 + j) * C;
                            for (int t = 1; t < C; t++)
                                if (samp[base+t] !== samp[base]) fr_ok = 1'b0;
                            if (j == 0 && samp[base] !== 1'b0) fr_ok = 1'b0;
                            if (j == 9 && samp[base] !== 1'b1) fr_ok = 1'b0;
                            if (j >= 1 && j <= 8) got[j-1] = samp[base];
                        end
                        checks++;
                        if (!fr_ok || got !== exp_byte(rec, b)) begin
                            errors++;
                            $display("FAIL frame_byte%0d got %02h framing_ok=%0d required %02h framing_ok=1",
                                     b, got, fr_ok, exp_byte(rec, b));
                        end
                    end
                end
            end
        end
    end

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b required %b", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic pulse(input logic [31:0] r, input logic [3:0] f);
        result_valid = 1'b1;
        result_in = r;
        flags_in = f;
        @(posedge CLOCK_50);
        #1;
        result_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(rem == 0 && mq.size() == 0) && n < limit) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_idle got timeout after %0d cycles required drain", n);
        end
    endtask

    task automatic wait_rem(input int target, input int limit);
        int n = 0;
        while (rem != target && n < limit) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_rem got rem %0d required %0d", rem, target);
        end
    endtask

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_en = 1'b1;
        check1("reset_txd", uart_txd, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_overflow", overflow, 1'b0);
        reset = 1'b0;
        idle(3);

        // Basic frame.
        pulse(32'h12345678, 4'b1001);
        check1("s1_busy_rise", busy, 1'b1);
        wait_idle(2000);
        idle(5);

        // Full FIFO with push on the pop edge.
        pulse(32'hA0000001, 4'h1);
        idle(5);
        pulse(32'hA0000002, 4'h2);
        idle(5);
        pulse(32'hA0000003, 4'h3);
        wait_rem(0, 2000);
        pulse(32'hA0000004, 4'h4);
        check1("s3_overflow_clear", overflow, 1'b0);
        wait_idle(4000);
        idle(5);

        // Buffering and overflow.
        for (int i = 1; i <= 4; i++) begin
            pulse(32'(i), 4'h5);
            idle(9);
        end
        check1("s2_overflow_set", overflow, 1'b1);
        wait_idle(4000);
        idle(5);
        check1("s2_overflow_sticky", overflow, 1'b1);

        // Reset mid-frame during B2 data, together with a snapshot pulse.
        pulse(32'hDEADBEEF, 4'hC);
        wait_rem(FRAME - 25 * C, 2000);
        reset = 1'b1;
        result_valid = 1'b1;
        result_in = 32'hCAFEF00D;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        result_valid = 1'b0;
        check1("s4_txd", uart_txd, 1'b1);
        check1("s4_busy", busy, 1'b0);
        check1("s4_overflow", overflow, 1'b0);
        idle(300);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                idle(1);
                reset = 1'b0;
            end
            pulse($urandom, 4'($urandom_range(0, 15)));
            idle($urandom_range(0, 260));
        end
        wait_idle(5000);
        idle(5);
        checks++;
        if (sb_rec.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending frames required 0", sb_rec.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
